// File: rtl/uart_bus_master.sv
// uart_bus_master: configures the UART register port, then polls status and moves bytes
// between the data register and the TX/RX streams. Optional macro: UART_MASTER_IRQ_EN.
module uart_bus_master #(
    parameter int REG_DATA_BITS = 32,
    parameter int DATA_BITS = 8,
    parameter logic [REG_DATA_BITS-1:0] CTRL_INIT = 32'h0000_001F,
    parameter logic [REG_DATA_BITS-1:0] MASK_INIT = 32'h0000_000A,
    parameter int POLL_GAP = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [1:0]               address,
    output logic                     rd,
    output logic                     wr,
    output logic [REG_DATA_BITS-1:0] wr_data,
    input  logic [REG_DATA_BITS-1:0] rd_data,
    input  logic                     irq,
    input  logic                     tx_valid,
    input  logic [DATA_BITS-1:0]     tx_byte,
    output logic                     tx_ready,
    output logic                     rx_valid,
    output logic [DATA_BITS-1:0]     rx_byte,
    input  logic                     rx_ready,
    output logic                     cfg_done,
    output logic                     rx_err,
    input  logic                     clr_err
);
    localparam int CNT_W = $clog2(POLL_GAP + 1);
    localparam int ST_RX_EMPTY = 6;
    localparam int ST_TX_FULL  = 7;
    localparam int ST_RX_ERR   = 9;

    // CFG_* name the write issued at the next edge; the others name the cycle on the bus now
    typedef enum logic [2:0] {CFG_CTRL, CFG_MASK, WAIT, POLL, RX_READ, TX_WRITE, IRQ_CLR} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_rx;
    logic             rx_pend, tx_pend, serve_rx, serve_tx, decide, irq_wake;

`ifdef UART_MASTER_IRQ_EN
    logic sv_rx, sv_tx;
    always_comb begin
        if (state == IRQ_CLR) begin
            rx_pend = sv_rx && !rx_valid;
            tx_pend = sv_tx && tx_valid;
        end else begin
            rx_pend = !rd_data[ST_RX_EMPTY] && !rx_valid;
            tx_pend = tx_valid && !rd_data[ST_TX_FULL];
        end
    end
    assign decide   = (state == POLL && !irq) || state == IRQ_CLR;
    assign irq_wake = irq;
`else
    logic unused_irq;
    always_comb begin
        rx_pend = !rd_data[ST_RX_EMPTY] && !rx_valid;
        tx_pend = tx_valid && !rd_data[ST_TX_FULL];
    end
    assign decide     = state == POLL;
    assign irq_wake   = 1'b0;
    assign unused_irq = irq;
`endif

    logic unused_status;
    assign unused_status = ^{rd_data[REG_DATA_BITS-1:10], rd_data[8]};

    // Contention alternates; last_rx=0 after reset so RX goes first
    assign serve_rx = rx_pend && (!tx_pend || !last_rx);
    assign serve_tx = tx_pend && !serve_rx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CFG_CTRL;
            address  <= 2'd0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            wr_data  <= '0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_byte  <= '0;
            cfg_done <= 1'b0;
            rx_err   <= 1'b0;
            cnt      <= '0;
            last_rx  <= 1'b0;
`ifdef UART_MASTER_IRQ_EN
            sv_rx    <= 1'b0;
            sv_tx    <= 1'b0;
`endif
        end else begin
            rd       <= 1'b0;
            wr       <= 1'b0;
            tx_ready <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (state == POLL && rd_data[ST_RX_ERR])
                rx_err <= 1'b1;
            else if (clr_err)
                rx_err <= 1'b0;

            case (state)
                CFG_CTRL: begin
                    wr      <= 1'b1;
                    address <= 2'd1;
                    wr_data <= CTRL_INIT;
                    state   <= CFG_MASK;
                end
                CFG_MASK: begin
                    wr       <= 1'b1;
                    address  <= 2'd2;
                    wr_data  <= MASK_INIT;
                    cfg_done <= 1'b1;
                    cnt      <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // cnt counts idle cycles already presented on the bus
                    if (cnt == CNT_W'(POLL_GAP) || irq_wake) begin
                        rd      <= 1'b1;
                        address <= 2'd1;
                        state   <= POLL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_READ: begin
                    rx_byte  <= rd_data[DATA_BITS-1:0];
                    rx_valid <= 1'b1;
                    rd       <= 1'b1;
                    address  <= 2'd1;
                    state    <= POLL;
                end
                TX_WRITE: begin
                    rd      <= 1'b1;
                    address <= 2'd1;
                    state   <= POLL;
                end
                default: ;
            endcase

            if (decide) begin
                if (serve_rx) begin
                    rd      <= 1'b1;
                    address <= 2'd0;
                    last_rx <= 1'b1;
                    state   <= RX_READ;
                end else if (serve_tx) begin
                    wr       <= 1'b1;
                    address  <= 2'd0;
                    wr_data  <= {{(REG_DATA_BITS-DATA_BITS){1'b0}}, tx_byte};
                    tx_ready <= 1'b1;
                    last_rx  <= 1'b0;
                    state    <= TX_WRITE;
                end else begin
                    cnt   <= CNT_W'(1);
                    state <= WAIT;
                end
            end
`ifdef UART_MASTER_IRQ_EN
            if (state == POLL && irq) begin
                wr      <= 1'b1;
                address <= 2'd3;
                wr_data <= '1;
                sv_rx   <= rx_pend;
                sv_tx   <= tx_pend;
                state   <= IRQ_CLR;
            end
`endif
        end
    end
endmodule
